i2s_rx: RTL and testbench

//  Slave-mode I2S receiver: samples external bck/lrck/din (e.g. from an ADC) in the clk domain.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_rx_sync_edge.sv | 32 +++
 rtl/i2s_rx.sv | 129 ++++++++++++
 tb/tb_i2s_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the slave-mode I2S receiver.
package i2s_pkg;

    localparam int I2S_SAMPLE_BITS_DEF = 16;
    localparam int I2S_SLOT_BITS_DEF   = 16;
    localparam int I2S_CNT_W           = 6;

    localparam logic [I2S_CNT_W-1:0] I2S_CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Two-flop synchroniser for a bundle of asynchronous pins; bit 0 additionally
// gets a one-clk rising-edge tick taken from the synchronised level.
module i2s_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic         rise
);

    logic [W-1:0] meta;
    logic         prev0;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the two sync stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= '0;
            sync_out <= '0;
            prev0    <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
            prev0    <= sync_out[0];
        end
    end

    assign rise = sync_out[0] & ~prev0;

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: recovers left/right sample pairs from bck/lrck/din.
// Optional slot-length checking is enabled by defining I2S_RX_FRAME_CHK_EN.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = I2S_SAMPLE_BITS_DEF,
    parameter int SLOT_BITS   = I2S_SLOT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bck,
    input  logic                   lrck,
    input  logic                   din,
    output logic [SAMPLE_BITS-1:0] left,
    output logic [SAMPLE_BITS-1:0] right,
    output logic                   valid,
    output logic                   frame_err
);

    logic [2:0]             pins_s;
    logic                   bck_rise;

    logic                   tick;
    logic                   lrck_t;
    logic                   din_t;
    logic                   lrck_prev;

    i2s_state_e             state;
    logic [I2S_CNT_W-1:0]   cnt;
    logic [I2S_CNT_W-1:0]   idx;
    logic [SAMPLE_BITS-1:0] word;
    logic [SAMPLE_BITS-1:0] word_next;
    logic [SAMPLE_BITS-1:0] holding;
    logic                   in_win;
    logic                   edge_tr;

    // bck is bit 0 so it gets the edge detector; lrck/din come from the same stage.
    i2s_sync_edge #(.W(3)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in ({din, lrck, bck}),
        .sync_out (pins_s),
        .rise     (bck_rise)
    );

    // Edge register: lrck/din sampled at the very stage where the bck rise appeared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick   <= 1'b0;
            lrck_t <= 1'b0;
            din_t  <= 1'b0;
        end else begin
            tick   <= bck_rise;
            lrck_t <= pins_s[1];
            din_t  <= pins_s[2];
        end
    end

    // idx is the edge number of the current tick relative to the last transition.
    always_comb begin
        idx       = (cnt == I2S_CNT_MAX) ? cnt : cnt + 1'b1;
        in_win    = int'(idx) <= SAMPLE_BITS;
        edge_tr   = lrck_t != lrck_prev;
        word_next = word;
        if (in_win) begin
            word_next = word | ({{(SAMPLE_BITS-1){1'b0}}, din_t} << (SAMPLE_BITS - int'(idx)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            cnt       <= '0;
            word      <= '0;
            holding   <= '0;
            lrck_prev <= 1'b0;
            left      <= '0;
            right     <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick) begin
                lrck_prev <= lrck_t;
                if (edge_tr) begin
                    cnt  <= '0;
                    word <= '0;
                end else begin
                    cnt  <= idx;
                    word <= word_next;
                end

                // A word closes on the transition tick, after its final bit was merged.
                case (state)
                    HUNT: begin
                        if (edge_tr && !lrck_t) state <= LEFT;
                    end
                    LEFT: begin
                        if (edge_tr) begin
                            holding <= word_next;
                            state   <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (edge_tr) begin
                            left  <= holding;
                            right <= word_next;
                            valid <= 1'b1;
                            state <= LEFT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef I2S_RX_FRAME_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (tick && edge_tr && (state != HUNT) && (int'(idx) != SLOT_BITS)) begin
            frame_err <= 1'b1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S source model drives both a 16-slot and a
// 32-slot receiver; expected samples come from the vector table and constants.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bck = 1'b1;
    logic        lrck = 1'b0;
    logic        din = 1'b0;
    logic [15:0] left, right, left32, right32;
    logic        valid, frame_err, valid32, frame_err32;

`ifdef I2S_RX_FRAME_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    i2s_rx dut (
        .clk(clk), .rst_n(rst_n), .bck(bck), .lrck(lrck), .din(din),
        .left(left), .right(right), .valid(valid), .frame_err(frame_err)
    );

    i2s_rx #(.SAMPLE_BITS(16), .SLOT_BITS(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bck(bck), .lrck(lrck), .din(din),
        .left(left32), .right(right32), .valid(valid32), .frame_err(frame_err32)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int vcnt32 = 0;
    int bad_double = 0;
    int bad_change = 0;
    logic [15:0] pl = '0, pr = '0;
    logic pv = 1'b0;
    logic rst_at_edge = 1'b0;
    logic carry = 1'b0;
    bit tail_pending = 1'b0;

    always @(posedge clk) rst_at_edge <= rst_n;

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (valid32) vcnt32++;
        if (valid && pv) bad_double++;
        if (rst_at_edge && !valid && (left !== pl || right !== pr)) bad_change++;
        pl = left;
        pr = right;
        pv = valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic gbit(input logic [15:0] w, input int i, input int nd);
        return (i < nd) ? w[15-i] : 1'b0;
    endfunction

    // One bck period: data changes while bck is low, receiver samples on the rise.
    task automatic drive_bit(input logic l, input logic d);
        bck = 1'b0; lrck = l; din = d;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Period 0 of a slot carries the previous channel's last bit (one-bit I2S delay).
    task automatic send_slot(input logic ch, input logic [15:0] w, input int s, input int nd);
        for (int k = 0; k < s; k++) begin
            if (k == 0 && tail_pending) begin
                tail_pending = 1'b0;
            end else begin
                drive_bit(ch, (k == 0) ? carry : gbit(w, k - 1, nd));
            end
        end
        carry = gbit(w, s - 1, nd);
    endtask

    task automatic send_frames(input logic [15:0] l, input logic [15:0] r,
                               input int s, input int nd, input int n);
        for (int f = 0; f < n; f++) begin
            send_slot(1'b0, l, s, nd);
            send_slot(1'b1, r, s, nd);
        end
    endtask

    // First period of the next left slot: closes the pending right word.
    task automatic send_tail();
        drive_bit(1'b0, carry);
        tail_pending = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          s;
        int          nd;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic        ferr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int vc0;
        vecs[0] = '{16'hA5C3, 16'h3C5A, 16, 16, 16'hA5C3, 16'h3C5A, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 16, 16, 16'hFFFF, 16'h0000, 1'b0};
        vecs[2] = '{16'h0001, 16'h8000, 16, 16, 16'h0001, 16'h8000, 1'b0};
        vecs[3] = '{16'hFFF0, 16'hABC0, 12, 12, 16'hFFF0, 16'hABC0, 1'b1};

        repeat (4) @(negedge clk);
        check("reset_left", {16'h0, left}, 32'h0);
        check("reset_right", {16'h0, right}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_ferr", {31'h0, frame_err}, 32'h0);
        rst_n = 1'b1;

        // Warm-up: the first frame after reset is only used to lock on.
        vc0 = vcnt;
        send_frames(16'hA5C3, 16'h3C5A, 16, 16, 2);
        send_tail();
        check("warm_valid_cnt", vcnt - vc0, 1);
        check("warm_left", {16'h0, left}, 32'hA5C3);
        check("warm_right", {16'h0, right}, 32'h3C5A);

        for (int i = 0; i < 4; i++) begin
            vc0 = vcnt;
            send_frames(vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].nd, 2);
            send_tail();
            check($sformatf("vec%0d_valid_cnt", i), vcnt - vc0, 2);
            check($sformatf("vec%0d_left", i), {16'h0, left}, {16'h0, vecs[i].exp_l});
            check($sformatf("vec%0d_right", i), {16'h0, right}, {16'h0, vecs[i].exp_r});
            check($sformatf("vec%0d_ferr", i), {31'h0, frame_err}, {31'h0, CHK & vecs[i].ferr});
        end

        // Sticky error survives well-formed frames.
        send_frames(16'h1111, 16'h2222, 16, 16, 1);
        send_tail();
        check("ferr_sticky", {31'h0, frame_err}, {31'h0, CHK});

        // One-clk reset inside a left slot.
        vc0 = vcnt;
        fork
            begin
                send_frames(16'h0F0F, 16'hF0F0, 16, 16, 3);
                send_tail();
            end
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("rst1_left", {16'h0, left}, 32'h0);
                check("rst1_right", {16'h0, right}, 32'h0);
                check("rst1_valid", {31'h0, valid}, 32'h0);
                check("rst1_ferr", {31'h0, frame_err}, 32'h0);
                rst_n = 1'b1;
            end
        join
        check("rst1_valid_cnt", vcnt - vc0, 2);
        check("rst1_left_after", {16'h0, left}, 32'h0F0F);
        check("rst1_right_after", {16'h0, right}, 32'hF0F0);
        check("rst1_ferr_after", {31'h0, frame_err}, 32'h0);

        // Reset released in the middle of a right slot.
        vc0 = vcnt;
        rst_n = 1'b0;
        fork
            begin
                send_frames(16'h1234, 16'hFEDC, 16, 16, 3);
                send_tail();
            end
            begin
                repeat (184) @(negedge clk);
                check("rst2_left_zero", {16'h0, left}, 32'h0);
                rst_n = 1'b1;
            end
        join
        check("rst2_valid_cnt", vcnt - vc0, 2);
        check("rst2_left", {16'h0, left}, 32'h1234);
        check("rst2_right", {16'h0, right}, 32'hFEDC);

        // bck stopped for 1000 clk between the left and right slots.
        vc0 = vcnt;
        send_slot(1'b0, 16'h6DB6, 16, 16);
        repeat (1000) @(negedge clk);
        check("stop_valid_cnt", vcnt - vc0, 0);
        check("stop_left_held", {16'h0, left}, 32'h1234);
        check("stop_right_held", {16'h0, right}, 32'hFEDC);
        send_slot(1'b1, 16'h9249, 16, 16);
        send_tail();
        check("resume_valid_cnt", vcnt - vc0, 1);
        check("resume_left", {16'h0, left}, 32'h6DB6);
        check("resume_right", {16'h0, right}, 32'h9249);

        // 32-bit slots with 16 data bits, checked on the SLOT_BITS=32 instance.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vc0 = vcnt32;
        send_frames(16'h8001, 16'h7FFE, 32, 16, 3);
        send_tail();
        check("slot32_valid_cnt", vcnt32 - vc0, 2);
        check("slot32_left", {16'h0, left32}, 32'h8001);
        check("slot32_right", {16'h0, right32}, 32'h7FFE);
        check("slot32_ferr", {31'h0, frame_err32}, 32'h0);

        check("valid_back_to_back", bad_double, 0);
        check("output_change_without_valid", bad_change, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
